mem_wb: RTL and testbench

MEM_WB -- requirements
Module: mem_wb

---
 rtl/mem_wb.sv | 170 +++++++++++++++++
 tb/tb_mem_wb.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb.sv
// mem_wb : MEM/WB pipeline register with load data alignment and RAM wait handling.
//
// Holds one latched instruction from the MEM stage and presents the register-file
// write for it. Loads are aligned and extended from the RAM read word. While an
// aligned load waits for ram_ready, the stage stalls the upstream pipeline. A load
// that waits TIMEOUT cycles is dropped with a one-cycle bus_error.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   stall, flush              pipeline hold request / bubble insertion
//   mem_*_flag_in, mem_sel_in access flags and size (0001 byte, 0011 half, 1111 word)
//   result_in                 ALU result, byte address for loads
//   reg_write_en_in/_addr_in  destination register from MEM
//   current_pc_addr_in        PC of the instruction
//   ram_read_data, ram_ready  RAM read word and its valid flag
//   reg_write_en_out/_addr_out, reg_write_data   register-file write port
//   current_pc_addr_out       latched PC (debug)
//   wb_stall_req              stall request to all upstream stages
//   load_misalign, bus_error  one-cycle error indications
module mem_wb #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic        mem_read_flag_in,
   input  logic        mem_write_flag_in,
   input  logic        mem_ext_flag_in,
   input  logic [3:0]  mem_sel_in,
   input  logic [31:0] result_in,
   input  logic        reg_write_en_in,
   input  logic [4:0]  reg_write_addr_in,
   input  logic [31:0] current_pc_addr_in,
   input  logic [31:0] ram_read_data,
   input  logic        ram_ready,
   output logic        reg_write_en_out,
   output logic [4:0]  reg_write_addr_out,
   output logic [31:0] reg_write_data,
   output logic [31:0] current_pc_addr_out,
   output logic        wb_stall_req,
   output logic        load_misalign,
   output logic        bus_error
);

   typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   // Latched instruction
   logic        v_read, v_write, v_ext, v_reg_write_en;
   logic [3:0]  v_sel;
   logic [31:0] v_result, v_pc;
   logic [4:0]  v_reg_write_addr;

   state_t      state, state_next;
   logic [7:0]  cnt, cnt_next;
   logic        advance;

   logic        load_ok;
   logic [7:0]  byte_val;
   logic [15:0] half_val;
   logic [31:0] load_data;

   // The store flag is latched with the rest of the instruction, but a store needs
   // no write-back action, so nothing downstream consumes it.
   logic        unused_store;
   assign unused_store = v_write;

   assign advance = !stall && !wb_stall_req;

   // NOTE: every register here is plain flop state, so all of it is cleared by
   // the asynchronous reset; sequential state is written with <= only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v_read           <= 1'b0;
         v_write          <= 1'b0;
         v_ext            <= 1'b0;
         v_sel            <= 4'd0;
         v_result         <= 32'd0;
         v_reg_write_en   <= 1'b0;
         v_reg_write_addr <= 5'd0;
         v_pc             <= 32'd0;
      end else if (advance) begin
         if (flush) begin
            v_read           <= 1'b0;
            v_write          <= 1'b0;
            v_ext            <= 1'b0;
            v_sel            <= 4'd0;
            v_result         <= 32'd0;
            v_reg_write_en   <= 1'b0;
            v_reg_write_addr <= 5'd0;
            v_pc             <= 32'd0;
         end else begin
            v_read           <= mem_read_flag_in;
            v_write          <= mem_write_flag_in;
            v_ext            <= mem_ext_flag_in;
            v_sel            <= mem_sel_in;
            v_result         <= result_in;
            v_reg_write_en   <= reg_write_en_in;
            v_reg_write_addr <= reg_write_addr_in;
            v_pc             <= current_pc_addr_in;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= 8'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Load alignment and lane extraction
   always_comb begin
      // NOTE: defaults first so every path assigns every output (no latches).
      load_ok   = 1'b0;
      load_data = ram_read_data;
      byte_val  = ram_read_data[8*v_result[1:0] +: 8];
      half_val  = v_result[1] ? ram_read_data[31:16] : ram_read_data[15:0];
      case (v_sel)
         4'b0001: begin
            load_ok   = 1'b1;
            load_data = {{24{v_ext & byte_val[7]}}, byte_val};
         end
         4'b0011: begin
            load_ok   = !v_result[0];
            load_data = {{16{v_ext & half_val[15]}}, half_val};
         end
         4'b1111: load_ok = (v_result[1:0] == 2'b00);
         default: load_ok = 1'b0;
      endcase
   end

   // FSM next state and write-back outputs
   always_comb begin
      state_next       = IDLE;
      cnt_next         = 8'd0;
      wb_stall_req     = 1'b0;
      load_misalign    = 1'b0;
      bus_error        = 1'b0;
      reg_write_en_out = 1'b0;
      reg_write_data   = 32'd0;
      case (state)
         ERR: bus_error = 1'b1;
         default: begin
            if (v_read && !load_ok) begin
               load_misalign = 1'b1;
            end else if (v_read && !ram_ready) begin
               wb_stall_req = 1'b1;
               cnt_next     = cnt + 8'd1;
               state_next   = (cnt_next == TIMEOUT_CNT) ? ERR : WAIT;
            end else if (v_read) begin
               reg_write_en_out = v_reg_write_en;
               reg_write_data   = load_data;
            end else begin
               reg_write_en_out = v_reg_write_en;
               reg_write_data   = v_result;
            end
         end
      endcase
   end

   assign reg_write_addr_out  = v_reg_write_addr;
   assign current_pc_addr_out = v_pc;

endmodule

// File: tb/tb_mem_wb.sv
// tb_mem_wb : self-checking bench for mem_wb (TIMEOUT=4) with directed scenarios
// and a randomized run against a behavioural model of the write-back stage.
module tb_mem_wb;

   localparam int TMO = 4;

   typedef struct packed {
      logic        rd, wr, ext;
      logic [3:0]  sel;
      logic [31:0] res;
      logic        we;
      logic [4:0]  addr;
      logic [31:0] pc;
   } ins_t;

   logic        clk, rst, stall, flush;
   logic        mem_read_flag_in, mem_write_flag_in, mem_ext_flag_in;
   logic [3:0]  mem_sel_in;
   logic [31:0] result_in, current_pc_addr_in, ram_read_data;
   logic        reg_write_en_in, ram_ready;
   logic [4:0]  reg_write_addr_in;
   logic        reg_write_en_out, wb_stall_req, load_misalign, bus_error;
   logic [4:0]  reg_write_addr_out;
   logic [31:0] reg_write_data, current_pc_addr_out;

   int total = 0;
   int bad   = 0;

   // Model state: instruction sitting in WB, whether it is in its error cycle,
   // and how many cycles it has waited for RAM so far.
   ins_t m_ins;
   bit   m_err;
   int   m_wait;

   // Expected outputs for the current cycle
   logic        exp_we, exp_stall, exp_mis, exp_berr, chk_data;
   logic [31:0] exp_data;

   mem_wb #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .mem_read_flag_in(mem_read_flag_in), .mem_write_flag_in(mem_write_flag_in),
      .mem_ext_flag_in(mem_ext_flag_in), .mem_sel_in(mem_sel_in),
      .result_in(result_in), .reg_write_en_in(reg_write_en_in),
      .reg_write_addr_in(reg_write_addr_in), .current_pc_addr_in(current_pc_addr_in),
      .ram_read_data(ram_read_data), .ram_ready(ram_ready),
      .reg_write_en_out(reg_write_en_out), .reg_write_addr_out(reg_write_addr_out),
      .reg_write_data(reg_write_data), .current_pc_addr_out(current_pc_addr_out),
      .wb_stall_req(wb_stall_req), .load_misalign(load_misalign), .bus_error(bus_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit load_legal(ins_t i);
      case (i.sel)
         4'b0001: return 1'b1;
         4'b0011: return (i.res % 2) == 0;
         4'b1111: return (i.res % 4) == 0;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] load_val(ins_t i, logic [31:0] rd);
      logic [31:0] v;
      if (i.sel == 4'b0001) begin
         v = (rd >> (8 * (i.res % 4))) & 32'hFF;
         if (i.ext && v >= 32'h80) v = v | 32'hFFFFFF00;
      end else if (i.sel == 4'b0011) begin
         v = (rd >> (16 * ((i.res / 2) % 2))) & 32'hFFFF;
         if (i.ext && v >= 32'h8000) v = v | 32'hFFFF0000;
      end else begin
         v = rd;
      end
      return v;
   endfunction

   function automatic ins_t mk(bit rd, bit ext, logic [3:0] sel, logic [31:0] res,
                               logic [4:0] addr, logic [31:0] pc);
      ins_t i;
      i.rd = rd; i.wr = 1'b0; i.ext = ext; i.sel = sel; i.res = res;
      i.we = 1'b1; i.addr = addr; i.pc = pc;
      return i;
   endfunction

   task automatic set_ins(ins_t i);
      mem_read_flag_in   = i.rd;
      mem_write_flag_in  = i.wr;
      mem_ext_flag_in    = i.ext;
      mem_sel_in         = i.sel;
      result_in          = i.res;
      reg_write_en_in    = i.we;
      reg_write_addr_in  = i.addr;
      current_pc_addr_in = i.pc;
   endtask

   // Let combinational outputs settle, then derive the model's expectations.
   task automatic settle();
      #1;
      exp_we = 1'b0; exp_stall = 1'b0; exp_mis = 1'b0; exp_berr = 1'b0;
      exp_data = 32'd0; chk_data = 1'b1;
      if (m_err) begin
         exp_berr = 1'b1; chk_data = 1'b0;
      end else if (m_ins.rd && !load_legal(m_ins)) begin
         exp_mis = 1'b1;
      end else if (m_ins.rd && !ram_ready) begin
         exp_stall = 1'b1; chk_data = 1'b0;
      end else if (m_ins.rd) begin
         exp_we = m_ins.we; exp_data = load_val(m_ins, ram_read_data);
      end else begin
         exp_we = m_ins.we; exp_data = m_ins.res;
      end
   endtask

   // Rising edge: update the model from the inputs applied this cycle.
   task automatic clk_edge();
      ins_t nxt;
      nxt = {mem_read_flag_in, mem_write_flag_in, mem_ext_flag_in, mem_sel_in, result_in,
             reg_write_en_in, reg_write_addr_in, current_pc_addr_in};
      @(posedge clk);
      if (m_err) begin
         m_err = 1'b0; m_wait = 0;
      end else if (exp_stall) begin
         m_wait++;
         if (m_wait == TMO) m_err = 1'b1;
      end else begin
         m_wait = 0;
      end
      if (!stall && !exp_stall) m_ins = flush ? '0 : nxt;
      @(negedge clk);
   endtask

   task automatic model_reset();
      m_ins = '0; m_err = 1'b0; m_wait = 0;
   endtask

   task automatic test_reset();
      rst = 1'b0; stall = 1'b0; flush = 1'b0; ram_ready = 1'b0; ram_read_data = 32'd0;
      set_ins(mk(1'b1, 1'b1, 4'hF, 32'hFFFF_FFFF, 5'd31, 32'hFFFF_FFFF));
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      total++;
      if ({reg_write_en_out, reg_write_addr_out, reg_write_data, current_pc_addr_out,
           wb_stall_req, load_misalign, bus_error} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got we=%b addr=%h data=%h pc=%h st=%b mis=%b be=%b expected all 0",
                  reg_write_en_out, reg_write_addr_out, reg_write_data, current_pc_addr_out,
                  wb_stall_req, load_misalign, bus_error);
      end
      set_ins('0);
      rst = 1'b1;
      settle();
      total++;
      if (reg_write_en_out !== 1'b0 || reg_write_data !== 32'd0) begin
         bad++;
         $display("FAIL reset_release: got we=%b data=%h expected 0 0", reg_write_en_out, reg_write_data);
      end
      clk_edge();
   endtask

   task automatic test_loads();
      // lb 0x103 signed
      set_ins(mk(1'b1, 1'b1, 4'b0001, 32'h103, 5'd7, 32'h40));
      settle(); clk_edge();
      set_ins('0); ram_ready = 1'b1; ram_read_data = 32'h8011_2233;
      settle();
      total++;
      if (reg_write_data !== 32'hFFFF_FF80 || reg_write_en_out !== 1'b1 || reg_write_addr_out !== 5'd7) begin
         bad++;
         $display("FAIL lb_signed: got data=%h we=%b addr=%0d expected ffffff80 1 7",
                  reg_write_data, reg_write_en_out, reg_write_addr_out);
      end
      // lhu 0x102 unsigned
      set_ins(mk(1'b1, 1'b0, 4'b0011, 32'h102, 5'd8, 32'h44));
      clk_edge();
      set_ins('0); ram_read_data = 32'hBEEF_1234;
      settle();
      total++;
      if (reg_write_data !== 32'h0000_BEEF || reg_write_en_out !== 1'b1) begin
         bad++;
         $display("FAIL lhu: got data=%h we=%b expected 0000beef 1", reg_write_data, reg_write_en_out);
      end
      // lh 0x100 signed
      set_ins(mk(1'b1, 1'b1, 4'b0011, 32'h100, 5'd9, 32'h48));
      clk_edge();
      set_ins('0); ram_read_data = 32'h0000_F00D;
      settle();
      total++;
      if (reg_write_data !== 32'hFFFF_F00D || current_pc_addr_out !== 32'h48) begin
         bad++;
         $display("FAIL lh_signed: got data=%h pc=%h expected fffff00d 48", reg_write_data, current_pc_addr_out);
      end
      clk_edge();
   endtask

   task automatic test_misalign();
      set_ins(mk(1'b1, 1'b0, 4'b1111, 32'h101, 5'd3, 32'h50));
      ram_ready = 1'b1;
      settle(); clk_edge();
      set_ins(mk(1'b0, 1'b0, 4'b1111, 32'hCAFE_0001, 5'd4, 32'h54));
      settle();
      total++;
      if (load_misalign !== 1'b1 || reg_write_en_out !== 1'b0 || wb_stall_req !== 1'b0 || reg_write_data !== 32'd0) begin
         bad++;
         $display("FAIL misalign: got mis=%b we=%b st=%b data=%h expected 1 0 0 0",
                  load_misalign, reg_write_en_out, wb_stall_req, reg_write_data);
      end
      clk_edge(); settle();
      total++;
      if (load_misalign !== 1'b0 || reg_write_data !== 32'hCAFE_0001 || reg_write_en_out !== 1'b1) begin
         bad++;
         $display("FAIL misalign_next: got mis=%b data=%h we=%b expected 0 cafe0001 1",
                  load_misalign, reg_write_data, reg_write_en_out);
      end
      clk_edge();
   endtask

   task automatic test_ram_wait();
      int stalls = 0;
      set_ins(mk(1'b1, 1'b0, 4'b1111, 32'h200, 5'd10, 32'h60));
      ram_ready = 1'b1; settle(); clk_edge();
      set_ins(mk(1'b0, 1'b0, 4'b0000, 32'h0000_DEAD, 5'd11, 32'h64));
      ram_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         settle();
         if (wb_stall_req === 1'b1 && reg_write_en_out === 1'b0 && bus_error === 1'b0) stalls++;
         clk_edge();
      end
      total++;
      if (stalls != 3) begin
         bad++;
         $display("FAIL wait_stalls: got %0d stalled cycles expected 3", stalls);
      end
      ram_ready = 1'b1; ram_read_data = 32'h1234_5678;
      settle();
      total++;
      if (wb_stall_req !== 1'b0 || reg_write_en_out !== 1'b1 || reg_write_data !== 32'h1234_5678) begin
         bad++;
         $display("FAIL wait_write: got st=%b we=%b data=%h expected 0 1 12345678",
                  wb_stall_req, reg_write_en_out, reg_write_data);
      end
      clk_edge(); settle();
      total++;
      if (reg_write_data !== 32'h0000_DEAD || current_pc_addr_out !== 32'h64) begin
         bad++;
         $display("FAIL wait_held: got data=%h pc=%h expected 0000dead 64", reg_write_data, current_pc_addr_out);
      end
      clk_edge();
   endtask

   task automatic test_timeout();
      int stalls = 0;
      set_ins(mk(1'b1, 1'b0, 4'b1111, 32'h300, 5'd12, 32'h70));
      ram_ready = 1'b1; settle(); clk_edge();
      set_ins(mk(1'b0, 1'b0, 4'b0000, 32'h0000_BEEF, 5'd13, 32'h74));
      ram_ready = 1'b0;
      for (int c = 0; c < TMO; c++) begin
         settle();
         if (wb_stall_req === 1'b1 && bus_error === 1'b0) stalls++;
         clk_edge();
      end
      total++;
      if (stalls != TMO) begin
         bad++;
         $display("FAIL timeout_stalls: got %0d expected %0d", stalls, TMO);
      end
      settle();
      total++;
      if (bus_error !== 1'b1 || wb_stall_req !== 1'b0 || reg_write_en_out !== 1'b0) begin
         bad++;
         $display("FAIL timeout_err: got be=%b st=%b we=%b expected 1 0 0", bus_error, wb_stall_req, reg_write_en_out);
      end
      clk_edge(); settle();
      total++;
      if (bus_error !== 1'b0 || reg_write_data !== 32'h0000_BEEF || reg_write_en_out !== 1'b1) begin
         bad++;
         $display("FAIL timeout_after: got be=%b data=%h we=%b expected 0 0000beef 1",
                  bus_error, reg_write_data, reg_write_en_out);
      end
      clk_edge();
   endtask

   task automatic test_reset_mid();
      int stalls = 0;
      set_ins(mk(1'b1, 1'b0, 4'b1111, 32'h400, 5'd14, 32'h80));
      ram_ready = 1'b1; settle(); clk_edge();
      set_ins('0); ram_ready = 1'b0;
      repeat (2) begin settle(); clk_edge(); end
      #2 rst = 1'b0;
      #1;
      total++;
      if ({reg_write_en_out, reg_write_addr_out, reg_write_data, current_pc_addr_out,
           wb_stall_req, load_misalign, bus_error} !== '0) begin
         bad++;
         $display("FAIL reset_mid: got we=%b addr=%h data=%h pc=%h st=%b mis=%b be=%b expected all 0",
                  reg_write_en_out, reg_write_addr_out, reg_write_data, current_pc_addr_out,
                  wb_stall_req, load_misalign, bus_error);
      end
      @(negedge clk); rst = 1'b1; model_reset();
      set_ins(mk(1'b1, 1'b0, 4'b1111, 32'h404, 5'd15, 32'h84));
      settle(); clk_edge();
      set_ins('0);
      // A counter left at 2 would time out after two stalled cycles.
      for (int c = 0; c < TMO - 1; c++) begin
         settle();
         if (wb_stall_req === 1'b1 && bus_error === 1'b0) stalls++;
         clk_edge();
      end
      total++;
      if (stalls != TMO - 1) begin
         bad++;
         $display("FAIL reset_mid_cnt: got %0d clean stalls expected %0d", stalls, TMO - 1);
      end
      ram_ready = 1'b1; settle(); clk_edge();
   endtask

   task automatic test_random();
      ins_t r;
      for (int n = 0; n < 400; n++) begin
         r.rd   = ($urandom_range(0, 9) < 5);
         r.wr   = !r.rd && $urandom_range(0, 1) == 1;
         r.ext  = $urandom_range(0, 1) == 1;
         case ($urandom_range(0, 7))
            0, 1, 2: r.sel = 4'b0001;
            3, 4:    r.sel = 4'b0011;
            5, 6:    r.sel = 4'b1111;
            default: r.sel = 4'($urandom_range(0, 15));
         endcase
         r.res  = $urandom; r.we = $urandom_range(0, 1) == 1;
         r.addr = 5'($urandom_range(0, 31)); r.pc = $urandom;
         set_ins(r);
         ram_ready     = ($urandom_range(0, 9) < 6);
         ram_read_data = $urandom;
         stall         = ($urandom_range(0, 99) < 15);
         flush         = ($urandom_range(0, 99) < 10);
         settle();
         total++;
         if (wb_stall_req !== exp_stall || load_misalign !== exp_mis || bus_error !== exp_berr) begin
            bad++;
            $display("FAIL rand_ctl[%0d]: got st=%b mis=%b be=%b expected %b %b %b",
                     n, wb_stall_req, load_misalign, bus_error, exp_stall, exp_mis, exp_berr);
         end
         total++;
         if (reg_write_en_out !== exp_we || current_pc_addr_out !== m_ins.pc) begin
            bad++;
            $display("FAIL rand_we[%0d]: got we=%b pc=%h expected %b %h",
                     n, reg_write_en_out, current_pc_addr_out, exp_we, m_ins.pc);
         end
         if (chk_data) begin
            total++;
            if (reg_write_data !== exp_data || (exp_we && reg_write_addr_out !== m_ins.addr)) begin
               bad++;
               $display("FAIL rand_data[%0d]: got data=%h addr=%0d expected %h %0d",
                        n, reg_write_data, reg_write_addr_out, exp_data, m_ins.addr);
            end
         end
         clk_edge();
      end
      stall = 1'b0; flush = 1'b0;
   endtask

   initial begin
      test_reset();
      test_loads();
      test_misalign();
      test_ram_wait();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
